// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter and byte sequencer for the 8-bit test memory.
//
// Port A issues 4-byte reads (instruction fetch). Port B issues byte/half/word loads and
// stores. The granted transaction is split into single-byte request cycles on the memory
// port; every request is held in a wait state until the memory acknowledges it with
// i_mem_data_DV. Read bytes are reassembled little-endian into a zero-extended word.
//
// Ports:
//   i_clk, i_rst                  clock (rising edge), asynchronous active-high reset
//   i_a_request/i_a_address       port A read request and byte address
//   o_a_data/o_a_done             port A read word (held) and one-cycle completion pulse
//   i_b_request/i_b_write         port B request and store select
//   i_b_size/i_b_address          port B size (0 byte, 1 half, 2/3 word) and byte address
//   i_b_wdata                     port B store data, byte k in bits [8k+7:8k]
//   o_b_rdata/o_b_done            port B load word (held) and one-cycle completion pulse
//   o_mem_request/o_mem_write     memory request pulse and write strobe
//   o_mem_address/o_mem_data      memory byte address and write data
//   i_mem_data/i_mem_data_DV      memory read data and acknowledge
//   o_busy                        high whenever a transaction is in progress
module mem_arbiter #(
   parameter int unsigned ADDR_W = 12
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_a_request,
   input  logic [ADDR_W-1:0] i_a_address,
   output logic [31:0]       o_a_data,
   output logic              o_a_done,
   input  logic              i_b_request,
   input  logic              i_b_write,
   input  logic [1:0]        i_b_size,
   input  logic [ADDR_W-1:0] i_b_address,
   input  logic [31:0]       i_b_wdata,
   output logic [31:0]       o_b_rdata,
   output logic              o_b_done,
   output logic              o_mem_request,
   output logic              o_mem_write,
   output logic [ADDR_W-1:0] o_mem_address,
   output logic [7:0]        o_mem_data,
   input  logic [7:0]        i_mem_data,
   input  logic              i_mem_data_DV,
   output logic              o_busy
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

   state_e            state_q, state_d;
   logic [1:0]        k_q, k_d;            // index of the byte currently in flight
   logic [1:0]        last_k_q, last_k_d;  // index of the final byte (N-1)
   logic              last_b_q, last_b_d;  // 1 = port B held the most recent grant
   logic              gnt_b_q, gnt_b_d;    // port owning the current transaction
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              write_q, write_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       asm_q, asm_d;        // read assembly register
   logic [31:0]       a_data_q, a_data_d;
   logic [31:0]       b_rdata_q, b_rdata_d;

   logic              grant_b;
   logic [ADDR_W-1:0] cur_addr;
   logic [7:0]        wr_byte;
   logic [31:0]       asm_ins;
   logic              mem_active;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= StIdle;
         k_q       <= 2'd0;
         last_k_q  <= 2'd0;
         last_b_q  <= 1'b1;
         gnt_b_q   <= 1'b0;
         addr_q    <= '0;
         write_q   <= 1'b0;
         wdata_q   <= 32'd0;
         asm_q     <= 32'd0;
         a_data_q  <= 32'd0;
         b_rdata_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         last_k_q  <= last_k_d;
         last_b_q  <= last_b_d;
         gnt_b_q   <= gnt_b_d;
         addr_q    <= addr_d;
         write_q   <= write_d;
         wdata_q   <= wdata_d;
         asm_q     <= asm_d;
         a_data_q  <= a_data_d;
         b_rdata_q <= b_rdata_d;
      end
   end

   // Datapath helpers shared by next-state and output logic.
   always_comb begin
      cur_addr = addr_q + ADDR_W'(k_q);
      unique case (k_q)
         2'd0:    wr_byte = wdata_q[7:0];
         2'd1:    wr_byte = wdata_q[15:8];
         2'd2:    wr_byte = wdata_q[23:16];
         default: wr_byte = wdata_q[31:24];
      endcase
      asm_ins = asm_q | (32'(i_mem_data) << {k_q, 3'b000});
   end

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      last_k_d  = last_k_q;
      last_b_d  = last_b_q;
      gnt_b_d   = gnt_b_q;
      addr_d    = addr_q;
      write_d   = write_q;
      wdata_d   = wdata_q;
      asm_d     = asm_q;
      a_data_d  = a_data_q;
      b_rdata_d = b_rdata_q;
      // On a tie the port that did not win last time gets the grant.
      grant_b   = i_b_request && (!i_a_request || !last_b_q);

      unique case (state_q)
         StIdle: begin
            if (i_a_request || i_b_request) begin
               gnt_b_d  = grant_b;
               last_b_d = grant_b;
               k_d      = 2'd0;
               asm_d    = 32'd0;
               state_d  = StIssue;
               if (grant_b) begin
                  addr_d  = i_b_address;
                  write_d = i_b_write;
                  wdata_d = i_b_wdata;
                  unique case (i_b_size)
                     2'd0:    last_k_d = 2'd0;
                     2'd1:    last_k_d = 2'd1;
                     default: last_k_d = 2'd3;
                  endcase
               end else begin
                  addr_d   = i_a_address;
                  write_d  = 1'b0;
                  wdata_d  = 32'd0;
                  last_k_d = 2'd3;
               end
            end
         end
         StIssue: begin
            state_d = StWait;
         end
         StWait: begin
            if (i_mem_data_DV) begin
               if (!write_q) begin
                  asm_d = asm_ins;
               end
               if (k_q == last_k_q) begin
                  state_d = StDone;
                  // Result registers load here so the word is valid during the done pulse.
                  if (!write_q) begin
                     if (gnt_b_q) begin
                        b_rdata_d = asm_ins;
                     end else begin
                        a_data_d = asm_ins;
                     end
                  end
               end else begin
                  k_d     = 2'(k_q + 2'd1);
                  state_d = StIssue;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      mem_active    = (state_q == StIssue) || (state_q == StWait);
      o_busy        = (state_q != StIdle);
      o_mem_request = (state_q == StIssue);
      o_mem_address = mem_active ? cur_addr : '0;
      o_mem_write   = mem_active && write_q;
      o_mem_data    = (mem_active && write_q) ? wr_byte : 8'd0;
      o_a_done      = (state_q == StDone) && !gnt_b_q;
      o_b_done      = (state_q == StDone) && gnt_b_q;
      o_a_data      = a_data_q;
      o_b_rdata     = b_rdata_q;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_req;
   logic [11:0] a_addr;
   logic [31:0] a_data;
   logic        a_done;
   logic        b_req;
   logic        b_write;
   logic [1:0]  b_size;
   logic [11:0] b_addr;
   logic [31:0] b_wdata;
   logic [31:0] b_rdata;
   logic        b_done;
   logic        mem_req;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_dv;
   logic        busy;

   // Memory model: writes on the request edge, acknowledges mem_extra cycles after the
   // normal one-cycle latency.
   logic [7:0]  mem [0:4095];
   logic        mem_clr;
   logic        pend;
   int          cnt;
   int          mem_extra;
   logic        stray_dv;

   int tests = 0;
   int fails = 0;
   logic [31:0] model_a;
   logic [31:0] model_b;

   typedef struct {
      logic        port_b;
      logic        wr;
      logic [1:0]  size;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_data;
      int          exp_lat;
      int          exp_n;
      int          extra;
   } vec_t;

   vec_t vecs [9];

   mem_arbiter #(.ADDR_W(12)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_a_request   (a_req),
      .i_a_address   (a_addr),
      .o_a_data      (a_data),
      .o_a_done      (a_done),
      .i_b_request   (b_req),
      .i_b_write     (b_write),
      .i_b_size      (b_size),
      .i_b_address   (b_addr),
      .i_b_wdata     (b_wdata),
      .o_b_rdata     (b_rdata),
      .o_b_done      (b_done),
      .o_mem_request (mem_req),
      .o_mem_write   (mem_we),
      .o_mem_address (mem_addr),
      .o_mem_data    (mem_wdata),
      .i_mem_data    (mem_rdata),
      .i_mem_data_DV (mem_dv),
      .o_busy        (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
         pend <= 1'b0;
         cnt  <= 0;
      end else if (mem_req) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         pend <= 1'b1;
         cnt  <= mem_extra;
      end else if (pend) begin
         if (cnt == 0) pend <= 1'b0;
         else cnt <= cnt - 1;
      end
   end

   assign mem_dv    = (pend && cnt == 0) || stray_dv;
   assign mem_rdata = mem[mem_addr];

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [11:0] a);
      logic [31:0] w;
      logic [11:0] ai;
      for (int i = 0; i < 4; i++) begin
         ai = a + 12'(i);
         w[8*i +: 8] = mem[ai];
      end
      return w;
   endfunction

   task automatic run_vec(input string name, input vec_t v);
      int          cyc;
      int          pulses;
      int          bad_addr;
      int          hold_bad;
      int          other;
      logic        got;
      logic [11:0] last;
      logic [11:0] ea;
      mem_extra = v.extra;
      @(negedge clk);
      if (v.port_b) begin
         b_req   = 1'b1;
         b_write = v.wr;
         b_size  = v.size;
         b_addr  = v.addr;
         b_wdata = v.wdata;
      end else begin
         a_req  = 1'b1;
         a_addr = v.addr;
      end
      cyc = 0; pulses = 0; bad_addr = 0; hold_bad = 0; other = 0; got = 1'b0; last = '0;
      while (cyc < 100 && !got) begin
         @(posedge clk);
         #1;
         cyc++;
         if (mem_req) begin
            ea = v.addr + 12'(pulses);
            if (mem_addr !== ea || mem_we !== v.wr) bad_addr++;
            pulses++;
            last = mem_addr;
         end else if (busy && !a_done && !b_done && pulses > 0 && mem_addr !== last) begin
            hold_bad++;
         end
         if (v.port_b ? b_done : a_done) got = 1'b1;
         if (v.port_b ? a_done : b_done) other++;
      end
      a_req = 1'b0;
      b_req = 1'b0;
      check({name, "_latency"}, 32'(cyc), 32'(v.exp_lat));
      check({name, "_pulses"}, 32'(pulses), 32'(v.exp_n));
      check({name, "_addr_seq"}, 32'(bad_addr), 32'd0);
      check({name, "_addr_hold"}, 32'(hold_bad), 32'd0);
      check({name, "_other_done"}, 32'(other), 32'd0);
      if (v.wr) begin
         check({name, "_mem"}, mem_word(v.addr), v.exp_data);
      end else if (v.port_b) begin
         model_b = v.exp_data;
      end else begin
         model_a = v.exp_data;
      end
      check({name, "_a_data"}, a_data, model_a);
      check({name, "_b_rdata"}, b_rdata, model_b);
      @(posedge clk);
      #1;
      check({name, "_idle_after"}, {29'd0, busy, a_done, b_done}, 32'd0);
      mem_extra = 0;
   endtask

   initial begin
      int          cyc;
      int          n;
      int          overlap;
      int          dones;
      logic        hit;
      int          order [8];
      int          when [8];
      vec_t        fresh;

      vecs[0] = '{1'b1, 1'b1, 2'd2, 12'h010, 32'hDEADBEEF, 32'hDEADBEEF, 9, 4, 0};
      vecs[1] = '{1'b0, 1'b0, 2'd2, 12'h010, 32'h0, 32'hDEADBEEF, 9, 4, 0};
      vecs[2] = '{1'b1, 1'b1, 2'd0, 12'h005, 32'h000000A5, 32'h000000A5, 3, 1, 0};
      vecs[3] = '{1'b1, 1'b0, 2'd1, 12'h004, 32'h0, 32'h0000A500, 5, 2, 0};
      vecs[4] = '{1'b1, 1'b1, 2'd3, 12'hFFE, 32'h44332211, 32'h44332211, 9, 4, 0};
      vecs[5] = '{1'b0, 1'b0, 2'd2, 12'hFFE, 32'h0, 32'h44332211, 9, 4, 0};
      vecs[6] = '{1'b1, 1'b0, 2'd2, 12'h001, 32'h0, 32'h00000044, 9, 4, 0};
      vecs[7] = '{1'b1, 1'b0, 2'd0, 12'h005, 32'h0, 32'h000000A5, 3, 1, 0};
      vecs[8] = '{1'b0, 1'b0, 2'd2, 12'h010, 32'h0, 32'hDEADBEEF, 21, 4, 3};

      rst = 1'b1; a_req = 1'b0; a_addr = '0; b_req = 1'b0; b_write = 1'b0; b_size = '0;
      b_addr = '0; b_wdata = '0; mem_clr = 1'b1; mem_extra = 0; stray_dv = 1'b0;
      model_a = 32'd0; model_b = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      mem_clr = 1'b0;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_mem_ctl", {30'd0, mem_req, mem_we}, 32'd0);
      check("reset_mem_addr", {20'd0, mem_addr}, 32'd0);
      check("reset_mem_data", {24'd0, mem_wdata}, 32'd0);
      check("reset_a_data", a_data, 32'd0);
      check("reset_b_rdata", b_rdata, 32'd0);
      check("reset_dones", {30'd0, a_done, b_done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) run_vec($sformatf("v%0d", i), vecs[i]);

      // Stray acknowledge while idle must not start anything.
      @(negedge clk);
      stray_dv = 1'b1;
      @(posedge clk);
      #1;
      stray_dv = 1'b0;
      check("stray_dv_idle", {29'd0, busy, a_done, b_done}, 32'd0);
      run_vec("stray_after", vecs[7]);

      // Reset during the wait of the second byte of a word store.
      mem_extra = 3;
      @(negedge clk);
      b_req = 1'b1; b_write = 1'b1; b_size = 2'd2; b_addr = 12'h100; b_wdata = 32'hAABBCCDD;
      hit = 1'b0;
      cyc = 0;
      while (cyc < 60 && !hit) begin
         @(posedge clk);
         #1;
         cyc++;
         if (mem_req && mem_addr == 12'h101) hit = 1'b1;
      end
      check("rst_mid_reached", {31'd0, hit}, 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      check("rst_mid_mem", {18'd0, mem_req, mem_we, mem_addr}, 32'd0);
      check("rst_mid_data", a_data | b_rdata, 32'd0);
      model_a = 32'd0;
      model_b = 32'd0;
      @(negedge clk);
      b_req = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (a_done || b_done) dones++;
      end
      check("rst_mid_no_done", 32'(dones), 32'd0);
      check("rst_mid_mem_word", mem_word(12'h100), 32'h0000CCDD);
      mem_extra = 0;
      fresh = '{1'b1, 1'b1, 2'd2, 12'h100, 32'hAABBCCDD, 32'hAABBCCDD, 9, 4, 0};
      run_vec("rst_fresh", fresh);

      // Simultaneous requests after reset: A first, then strict alternation.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      a_req = 1'b1; a_addr = 12'h010;
      b_req = 1'b1; b_write = 1'b0; b_size = 2'd2; b_addr = 12'h004;
      n = 0; cyc = 0; overlap = 0;
      for (int i = 0; i < 8; i++) begin
         order[i] = -1;
         when[i]  = -1;
      end
      while (cyc < 200 && n < 8) begin
         @(posedge clk);
         #1;
         cyc++;
         if (a_done && b_done) overlap++;
         if (a_done || b_done) begin
            order[n] = b_done ? 1 : 0;
            when[n]  = cyc;
            n++;
         end
      end
      a_req = 1'b0;
      b_req = 1'b0;
      check("rr_overlap", 32'(overlap), 32'd0);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i % 2));
         check($sformatf("rr_time%0d", i), 32'(when[i]), 32'(9 + 10 * i));
      end
      check("rr_a_data", a_data, 32'hDEADBEEF);
      check("rr_b_rdata", b_rdata, 32'h0000A500);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of the byte-wide test memory. Accepts 32-bit-style transactions from an instruction-fetch port (A, read-only) and a load/store port (B), grants one at a time with round-robin, and splits each into single-byte request/data-valid cycles on the 8-bit memory port. Read bytes are reassembled little-endian and returned with a one-cycle done pulse.

## Interface
- ADDR_W, 12, memory port address width; all address arithmetic wraps modulo 2^ADDR_W
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_a_request  in  1  port A read request (level)
- i_a_address  in  ADDR_W  port A byte address
- o_a_data  out  32  port A read word
- o_a_done  out  1  port A completion pulse
- i_b_request  in  1  port B request (level)
- i_b_write  in  1  1 = store, 0 = load
- i_b_size  in  2  0 = byte, 1 = half, 2/3 = word
- i_b_address  in  ADDR_W  port B byte address
- i_b_wdata  in  32  store data, byte k in bits [8k+7:8k]
- o_b_rdata  out  32  load data, zero-extended
- o_b_done  out  1  port B completion pulse
- o_mem_request, o_mem_write  out  1  memory request / write strobe
- o_mem_address  out  ADDR_W  memory byte address
- o_mem_data  out  8  memory write data
- i_mem_data  in  8  memory read data (combinational from address)
- i_mem_data_DV  in  1  memory acknowledge, one cycle after request
- o_busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any request is high, grant, latch address/write/size/wdata of granted port, clear byte counter k and read assembly register, go to ISSUE. Port A always: read, 4 bytes.
- Byte count N: size 0 → 1, size 1 → 2, size 2/3 → 4.
- Arbitration: only A → A; only B → B; both → port not granted last. Last-grant pointer resets to B (A wins first tie); updated only on grant.
- ISSUE: o_mem_request = 1 for exactly this cycle, o_mem_address = base + k (wraps), o_mem_write = latched write, o_mem_data = wdata byte k (0 on reads). Go to WAIT.
- WAIT: hold o_mem_address and o_mem_write; o_mem_request = 0. Stay until i_mem_data_DV. On DV: reads capture i_mem_data into assembly bits [8k+7:8k]; if k = N−1 go to DONE, else k+1 and ISSUE.
- DONE: pulse granted port's done for one cycle; on read, drive assembled word (unused upper bytes 0) to that port's data output, registered, held until that port's next read completes. On B store, o_b_rdata unchanged. Go to IDLE.
- Unaligned addresses legal; no alignment check.
- i_mem_data_DV outside WAIT ignored. No timeout: missing DV stalls in WAIT.
- Requester keeps request and fields stable until its done; request still high in the IDLE cycle after DONE starts a new transaction (back-to-back permitted, arbitrated normally).

## Timing
- Reset (async, immediate): state IDLE, k = 0, pointer = B, all outputs 0 (o_a_data, o_b_rdata, done pulses, o_mem_*, o_busy).
- Request sampled high at the edge ending cycle T (IDLE): ISSUE in T+1, WAIT in T+2 (DV high with zero-wait memory), two cycles per byte, DONE (done = 1) in T+2N+1. Word: done at T+9; half: T+5; byte: T+3.
- Next transaction's grant no earlier than IDLE cycle T+2N+2; done pulses never overlap; at most one o_mem_request per two cycles.
- Reset mid-transaction: abort, no done, bytes already written stay written, later bytes never issued.

## Test plan
- B store word 0xDEADBEEF at 0x010 → four request pulses, bytes 0x10..0x13 = EF, BE, AD, DE; o_b_done at T+9; then A read 0x010 → o_a_data = 0xDEADBEEF, o_a_done at T+9.
- B store byte (size 0) 0x000000A5 at 0x005 → one request pulse, only byte 5 = A5, done at T+3; B load half at 0x004 (byte 4 = 0) → o_b_rdata = 0x0000A500, done at T+5.
- A and B request in the same cycle after reset → A served first, B immediately after; both again simultaneously → B now loses only if it was last granted (alternation verified over 4 rounds).
- A read word at 0xFFE → o_mem_address sequence 0xFFE, 0xFFF, 0x000, 0x001; word assembled little-endian.
- Reset asserted during WAIT of byte 2 of a word store → outputs 0 same cycle, no done, bytes 0–1 written, bytes 2–3 unchanged; after release, a fresh request completes normally.
- Memory DV delayed 3 extra cycles on each byte → controller holds address in WAIT, result correct, done latency grows by 12; stray DV pulse in IDLE → no effect.
